// File: rtl/multi_edge_detector_if.sv
`default_nettype none
// ============================================================================
// Module      : multi_edge_detector_if
// Description : Channel bundle between the edge detector and its user.
// Revision    : 1.0 - initial release
// ============================================================================
interface multi_edge_detector_if #(
    parameter int N = 4
);
    logic [N-1:0]   x;
    logic [2*N-1:0] mode;
    logic [N-1:0]   clr;
    logic [N-1:0]   irq_en;
    logic [N-1:0]   level;
    logic [N-1:0]   pulse;
    logic [N-1:0]   flag;
    logic           irq;

    modport master (
        output x, mode, clr, irq_en,
        input  level, pulse, flag, irq
    );

    modport slave (
        input  x, mode, clr, irq_en,
        output level, pulse, flag, irq
    );
endinterface
`default_nettype wire

// File: rtl/multi_edge_detector.sv
`default_nettype none
// ============================================================================
// Module      : multi_edge_detector
// Description : N-channel synchronised, debounced edge detector with sticky
//               flags and an aggregated interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_edge_detector #(
    parameter int N             = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    multi_edge_detector_if.slave    bus
);
    localparam int CNT_W = (FILTER_CYCLES + 1 > 2) ? $clog2(FILTER_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [N-1:0] w_level;
    logic [N-1:0] w_pulse;
    logic [N-1:0] w_flag;

    generate
        for (genvar i = 0; i < N; i++) begin : g_ch
            logic [SYNC_STAGES-1:0] r_sync;
            logic [CNT_W-1:0]       r_cnt;
            logic                   r_level;
            logic                   r_pulse;
            logic                   r_flag;
            logic                   w_s;
            logic                   w_update;
            logic                   w_event;

            assign w_s      = r_sync[SYNC_STAGES-1];
            // The level only moves after FILTER_CYCLES consecutive disagreeing samples.
            assign w_update = (w_s != r_level) && (r_cnt == C_CNT_LAST);
            assign w_event  = w_update &&
                              (( w_s && bus.mode[2*i])   ||
                               (!w_s && bus.mode[2*i+1]));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync  <= '0;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                    r_pulse <= 1'b0;
                    r_flag  <= 1'b0;
                end else begin
                    r_sync[0] <= bus.x[i];
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        r_sync[k] <= r_sync[k-1];
                    end

                    if (w_s == r_level) begin
                        r_cnt <= '0;
                    end else if (w_update) begin
                        r_level <= w_s;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end

                    r_pulse <= w_event;

                    // A new event takes priority over a clear in the same cycle.
                    if (w_event) begin
                        r_flag <= 1'b1;
                    end else if (bus.clr[i]) begin
                        r_flag <= 1'b0;
                    end
                end
            end

            assign w_level[i] = r_level;
            assign w_pulse[i] = r_pulse;
            assign w_flag[i]  = r_flag;
        end
    endgenerate

    assign bus.level = w_level;
    assign bus.pulse = w_pulse;
    assign bus.flag  = w_flag;
    assign bus.irq   = |(w_flag & bus.irq_en);
endmodule
`default_nettype wire

// File: tb/tb_multi_edge_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_edge_detector
// Description : Directed self-checking bench for multi_edge_detector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_edge_detector;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    multi_edge_detector_if #(.N(4)) bus  ();
    multi_edge_detector_if #(.N(1)) bus1 ();

    multi_edge_detector #(.N(4), .SYNC_STAGES(2), .FILTER_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    multi_edge_detector #(.N(1), .SYNC_STAGES(1), .FILTER_CYCLES(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic count_pulses(input int ch, input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            tick(1);
            if (bus.pulse[ch] === 1'b1) cnt++;
        end
    endtask

    initial begin
        int          cnt;
        logic [3:0]  seen;
        logic [1:0]  m_list [4];
        logic [1:0]  m;

        n_cmp       = 0;
        n_err       = 0;
        m_list      = '{2'b01, 2'b10, 2'b11, 2'b00};
        rst         = 1'b1;
        bus.x       = 4'h0;
        bus.mode    = 8'h55;
        bus.clr     = 4'h0;
        bus.irq_en  = 4'b0001;
        bus1.x      = 1'b0;
        bus1.mode   = 2'b01;
        bus1.clr    = 1'b0;
        bus1.irq_en = 1'b1;

        // Reset state
        tick(2);
        chk("rst_level", 32'(bus.level), 32'h0);
        chk("rst_pulse", 32'(bus.pulse), 32'h0);
        chk("rst_flag",  32'(bus.flag),  32'h0);
        chk("rst_irq",   32'(bus.irq),   32'h0);
        chk("rst_level1", 32'(bus1.level), 32'h0);
        rst = 1'b0;
        tick(3);
        chk("idle_level", 32'(bus.level), 32'h0);

        // Basic rising edge on channel 0, latency 6 edges
        bus.x = 4'b0001;
        tick(5);
        chk("t1_level_e5", 32'(bus.level), 32'h0);
        chk("t1_pulse_e5", 32'(bus.pulse), 32'h0);
        tick(1);
        chk("t1_level_e6", 32'(bus.level), 32'h1);
        chk("t1_pulse_e6", 32'(bus.pulse), 32'h1);
        chk("t1_flag_e6",  32'(bus.flag),  32'h1);
        chk("t1_irq_e6",   32'(bus.irq),   32'h1);
        tick(1);
        chk("t1_pulse_e7", 32'(bus.pulse), 32'h0);
        chk("t1_flag_e7",  32'(bus.flag),  32'h1);
        bus.clr = 4'b0001;
        tick(1);
        bus.clr = 4'b0000;
        chk("t1_flag_clr", 32'(bus.flag), 32'h0);
        chk("t1_irq_clr",  32'(bus.irq),  32'h0);

        // Glitch of 3 cycles is rejected
        bus.x = 4'b0011;
        seen  = 4'h0;
        tick(3);
        seen |= bus.pulse;
        bus.x = 4'b0001;
        repeat (8) begin
            tick(1);
            seen |= bus.pulse;
        end
        chk("t2_glitch_pulse", 32'(seen[1]), 32'h0);
        chk("t2_glitch_level", 32'(bus.level), 32'h1);
        chk("t2_glitch_flag",  32'(bus.flag),  32'h0);

        // 4-cycle high passes, one pulse on the rise only
        bus.x = 4'b0011;
        cnt   = 0;
        repeat (4) begin
            tick(1);
            if (bus.pulse[1] === 1'b1) cnt++;
        end
        bus.x = 4'b0001;
        repeat (10) begin
            tick(1);
            if (bus.pulse[1] === 1'b1) cnt++;
        end
        chk("t2_pass_pulses", 32'(cnt), 32'd1);
        chk("t2_pass_level",  32'(bus.level), 32'h1);
        chk("t2_pass_flag",   32'(bus.flag),  32'h2);
        bus.clr = 4'hF;
        tick(1);
        bus.clr = 4'h0;

        // Mode sweep on channel 2
        for (int j = 0; j < 4; j++) begin
            m             = m_list[j];
            bus.mode[5:4] = m;
            bus.x[2]      = 1'b1;
            count_pulses(2, 10, cnt);
            chk("t3_rise_pulses", 32'(cnt), 32'(m[0]));
            chk("t3_rise_level",  32'(bus.level[2]), 32'h1);
            chk("t3_rise_flag",   32'(bus.flag[2]),  32'(m[0]));
            bus.x[2] = 1'b0;
            count_pulses(2, 10, cnt);
            chk("t3_fall_pulses", 32'(cnt), 32'(m[1]));
            chk("t3_fall_level",  32'(bus.level[2]), 32'h0);
            chk("t3_fall_flag",   32'(bus.flag[2]),  32'(m != 2'b00));
            bus.clr[2] = 1'b1;
            tick(1);
            bus.clr[2] = 1'b0;
        end
        bus.mode[5:4] = 2'b01;

        // Flag clear and set-beats-clear on channel 3
        bus.irq_en = 4'b1000;
        bus.x[3]   = 1'b1;
        tick(6);
        chk("t4_flag_set", 32'(bus.flag[3]), 32'h1);
        chk("t4_irq_set",  32'(bus.irq),     32'h1);
        bus.clr[3] = 1'b1;
        tick(1);
        bus.clr[3] = 1'b0;
        chk("t4_flag_clr", 32'(bus.flag[3]), 32'h0);
        chk("t4_irq_clr",  32'(bus.irq),     32'h0);
        bus.x[3] = 1'b0;
        tick(10);
        chk("t4_fall_flag", 32'(bus.flag[3]), 32'h0);
        bus.x[3] = 1'b1;
        tick(5);
        bus.clr[3] = 1'b1;
        tick(1);
        bus.clr[3] = 1'b0;
        chk("t4_race_pulse", 32'(bus.pulse[3]), 32'h1);
        chk("t4_race_flag",  32'(bus.flag[3]),  32'h1);
        tick(1);
        chk("t4_race_hold",  32'(bus.flag[3]),  32'h1);
        chk("t4_race_irq",   32'(bus.irq),      32'h1);

        // Reset in the middle of a filter count
        bus.x = 4'h0;
        tick(12);
        bus.clr = 4'hF;
        tick(1);
        bus.clr    = 4'h0;
        bus.irq_en = 4'hF;
        chk("t5_pre_level", 32'(bus.level), 32'h0);
        bus.x = 4'b0001;
        tick(4);
        rst = 1'b1;
        #1;
        chk("t5_rst_level", 32'(bus.level), 32'h0);
        chk("t5_rst_pulse", 32'(bus.pulse), 32'h0);
        chk("t5_rst_flag",  32'(bus.flag),  32'h0);
        chk("t5_rst_irq",   32'(bus.irq),   32'h0);
        tick(2);
        chk("t5_rst_hold",  32'(bus.level), 32'h0);
        rst = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick(1);
            chk("t5_early_pulse", 32'(bus.pulse), 32'h0);
        end
        chk("t5_early_level", 32'(bus.level), 32'h0);
        tick(1);
        chk("t5_pulse", 32'(bus.pulse), 32'h1);
        chk("t5_level", 32'(bus.level), 32'h1);
        chk("t5_irq",   32'(bus.irq),   32'h1);

        // Minimal configuration: pulse after edge 2, every rising toggle
        bus1.x = 1'b1;
        tick(1);
        chk("t6_pulse_e1", 32'(bus1.pulse), 32'h0);
        tick(1);
        chk("t6_pulse_e2", 32'(bus1.pulse), 32'h1);
        bus1.x = 1'b0;
        cnt    = 1;
        tick(2);
        for (int p = 0; p < 4; p++) begin
            bus1.x = 1'b1;
            tick(1);
            chk("t6_hi_e1", 32'(bus1.pulse), 32'h0);
            tick(1);
            chk("t6_hi_e2", 32'(bus1.pulse), 32'h1);
            if (bus1.pulse === 1'b1) cnt++;
            bus1.x = 1'b0;
            tick(1);
            chk("t6_lo_e1", 32'(bus1.pulse), 32'h0);
            tick(1);
            chk("t6_lo_e2", 32'(bus1.pulse), 32'h0);
        end
        chk("t6_pulse_count", 32'(cnt), 32'd5);
        chk("t6_flag", 32'(bus1.flag), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
